// File: rtl/arm_pipe_pkg.sv
// Shared types and sizing helpers for the ARM pipeline hazard scoreboard.
package arm_pipe_pkg;

  // Register numbers are carried zero-extended to this width inside slots so
  // the slot struct is independent of the NUM_REGS chosen by the top level.
  localparam int SB_MAX_REG_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int SEL_REGFILE = 0;

  typedef logic [SB_MAX_REG_W-1:0] sb_reg_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic    valid;
    logic    wb_en;
    logic    mem_r_en;
    sb_reg_t dest;
    sb_reg_t src1;
    sb_reg_t src2;
    logic    two_src;
  } sb_slot_t;

  // Width of a register index; never narrower than one bit.
  function automatic int reg_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Width of a forwarding select covering slots 0..depth-1.
  function automatic int sel_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one pipeline slot against a pair of source registers.
// raw1/raw2 fire only for a live writer; raw2 is additionally gated by two_src.
module sb_match
  import arm_pipe_pkg::*;
(
  input  sb_slot_t slot,
  input  sb_reg_t  src1,
  input  sb_reg_t  src2,
  input  logic     two_src,
  output logic     raw1,
  output logic     raw2,
  output logic     is_load
);

  logic live_writer;

  assign live_writer = slot.valid & slot.wb_en;
  assign raw1        = live_writer & (slot.dest == src1);
  assign raw2        = live_writer & two_src & (slot.dest == src2);
  assign is_load     = slot.valid & slot.mem_r_en;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations from EXE (slot 0) to WB
// (slot DEPTH-1), raises the ID stall, picks EXE forwarding sources, and
// reports a busy-register mask plus a saturating stall counter.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter int DEPTH         = 3,
  parameter int LOAD_FWD_SLOT = 2,
  localparam int REG_W        = reg_w(NUM_REGS),
  localparam int SEL_W        = sel_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                forwarding_enabled,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                two_src,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic                flush,
  output logic                hazard_detected,
  output logic [SEL_W-1:0]    sel_src_1,
  output logic [SEL_W-1:0]    sel_src_2,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [31:0]         stall_count
);

  sb_slot_t    slot_reg [DEPTH];
  sb_slot_t    slot0_next;
  logic [31:0] stall_count_reg;

  // Per-slot match results against the ID sources and against slot 0's sources.
  logic [DEPTH-1:0] id_raw1, id_raw2, id_load;
  logic [DEPTH-1:0] fw_raw1, fw_raw2, fw_load;
  logic [DEPTH-1:0] unused_slot_bits;

  sb_reg_t id_src1_ext, id_src2_ext;
  assign id_src1_ext = sb_reg_t'(src1);
  assign id_src2_ext = sb_reg_t'(src2);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      sb_match u_id_match (
        .slot    (slot_reg[gi]),
        .src1    (id_src1_ext),
        .src2    (id_src2_ext),
        .two_src (two_src),
        .raw1    (id_raw1[gi]),
        .raw2    (id_raw2[gi]),
        .is_load (id_load[gi])
      );
      sb_match u_fw_match (
        .slot    (slot_reg[gi]),
        .src1    (slot_reg[0].src1),
        .src2    (slot_reg[0].src2),
        .two_src (slot_reg[0].two_src),
        .raw1    (fw_raw1[gi]),
        .raw2    (fw_raw2[gi]),
        .is_load (fw_load[gi])
      );
      // Source fields of older slots and some match results are not consumed.
      assign unused_slot_bits[gi] = ^{slot_reg[gi].src1, slot_reg[gi].src2, slot_reg[gi].two_src,
                                      id_raw1[gi], id_raw2[gi], id_load[gi],
                                      fw_raw1[gi], fw_raw2[gi], fw_load[gi]};
    end
  endgenerate

  // ID-stage stall: any RAW before WB without forwarding, load-use only with it.
  always_comb begin
    logic raw_any;
    logic load_raw_any;
    raw_any      = 1'b0;
    load_raw_any = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      raw_any = raw_any | id_raw1[j] | id_raw2[j];
      if (j < LOAD_FWD_SLOT - 1)
        load_raw_any = load_raw_any | ((id_raw1[j] | id_raw2[j]) & id_load[j]);
    end
    hazard_detected = id_valid & ~flush & (forwarding_enabled ? load_raw_any : raw_any);
  end

  // Forwarding selects: scan oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    sel_src_1 = SEL_W'(SEL_REGFILE);
    sel_src_2 = SEL_W'(SEL_REGFILE);
    if (forwarding_enabled && slot_reg[0].valid) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (fw_raw1[k] && (!fw_load[k] || k >= LOAD_FWD_SLOT)) sel_src_1 = SEL_W'(k);
        if (fw_raw2[k] && (!fw_load[k] || k >= LOAD_FWD_SLOT)) sel_src_2 = SEL_W'(k);
      end
    end
  end

  // Next EXE entry: the ID instruction when it advances, otherwise a bubble.
  always_comb begin
    slot0_next = '0;
    if (id_valid && !flush && !hazard_detected) begin
      slot0_next.valid    = 1'b1;
      slot0_next.wb_en    = id_wb_en;
      slot0_next.mem_r_en = id_mem_r_en;
      slot0_next.dest     = sb_reg_t'(id_dest);
      slot0_next.src1     = id_src1_ext;
      slot0_next.src2     = id_src2_ext;
      slot0_next.two_src  = two_src;
    end
  end

  // EXE slot load; reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) slot_reg[0] <= '0;
    else     slot_reg[0] <= slot0_next;
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      // Older slots advance one stage per cycle; the WB slot simply falls off.
      always_ff @(posedge clk) begin
        if (rst) slot_reg[gi] <= '0;
        else     slot_reg[gi] <= slot_reg[gi-1];
      end
    end
  endgenerate

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count_reg <= '0;
    else if (hazard_detected && stall_count_reg != 32'hFFFF_FFFF)
      stall_count_reg <= stall_count_reg + 32'd1;
  end

  assign stall_count = stall_count_reg;

  // Busy mask decoded purely from slot state.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++)
      for (int k = 0; k < DEPTH; k++)
        if (slot_reg[k].valid && slot_reg[k].wb_en && slot_reg[k].dest == sb_reg_t'(r))
          busy_mask[r] = 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NUM_REGS=16, DEPTH=3, LOAD_FWD_SLOT=2).
// The driver applies one vector per cycle and queues the hand-computed outputs;
// a monitor pops and compares them at the falling edge of the same cycle.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        forwarding_enabled;
  logic        id_valid;
  logic [3:0]  src1, src2, id_dest;
  logic        two_src, id_wb_en, id_mem_r_en, flush;
  logic        hazard_detected;
  logic [1:0]  sel_src_1, sel_src_2;
  logic [15:0] busy_mask;
  logic [31:0] stall_count;

  typedef struct {
    int          id;
    logic        haz;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [15:0] busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   vec_id     = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(16), .DEPTH(3), .LOAD_FWD_SLOT(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .forwarding_enabled (forwarding_enabled),
    .id_valid           (id_valid),
    .src1               (src1),
    .src2               (src2),
    .two_src            (two_src),
    .id_dest            (id_dest),
    .id_wb_en           (id_wb_en),
    .id_mem_r_en        (id_mem_r_en),
    .flush              (flush),
    .hazard_detected    (hazard_detected),
    .sel_src_1          (sel_src_1),
    .sel_src_2          (sel_src_2),
    .busy_mask          (busy_mask),
    .stall_count        (stall_count)
  );

  // One cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic fwd_i, input logic rst_i, input logic v_i, input logic fl_i,
                     input logic [3:0] s1_i, input logic [3:0] s2_i, input logic two_i,
                     input logic [3:0] d_i, input logic wb_i, input logic mr_i,
                     input logic eh, input logic [1:0] e1, input logic [1:0] e2,
                     input logic [15:0] eb, input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    forwarding_enabled = fwd_i;
    rst         = rst_i;
    id_valid    = v_i;
    flush       = fl_i;
    src1        = s1_i;
    src2        = s2_i;
    two_src     = two_i;
    id_dest     = d_i;
    id_wb_en    = wb_i;
    id_mem_r_en = mr_i;
    e.id = vec_id; e.haz = eh; e.s1 = e1; e.s2 = e2; e.busy = eb; e.cnt = ec;
    exp_q.push_back(e);
    vec_id++;
  endtask

  task automatic nop(input logic fwd_i, input logic rst_i, input logic eh, input logic [1:0] e1,
                     input logic [1:0] e2, input logic [15:0] eb, input logic [31:0] ec);
    cyc(fwd_i, rst_i, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, eh, e1, e2, eb, ec);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("vec %0d: haz=%0b sel1=%0d sel2=%0d busy=%h cnt=%0d",
                 e.id, hazard_detected, sel_src_1, sel_src_2, busy_mask, stall_count);
        compared++;
        if (hazard_detected !== e.haz) begin
          mismatched++;
          $display("FAIL vec%0d hazard: got %0b expected %0b", e.id, hazard_detected, e.haz);
        end
        compared++;
        if (sel_src_1 !== e.s1) begin
          mismatched++;
          $display("FAIL vec%0d sel_src_1: got %0d expected %0d", e.id, sel_src_1, e.s1);
        end
        compared++;
        if (sel_src_2 !== e.s2) begin
          mismatched++;
          $display("FAIL vec%0d sel_src_2: got %0d expected %0d", e.id, sel_src_2, e.s2);
        end
        compared++;
        if (busy_mask !== e.busy) begin
          mismatched++;
          $display("FAIL vec%0d busy_mask: got %h expected %h", e.id, busy_mask, e.busy);
        end
        compared++;
        if (stall_count !== e.cnt) begin
          mismatched++;
          $display("FAIL vec%0d stall_count: got %0d expected %0d", e.id, stall_count, e.cnt);
        end
      end
    end
  end

  // Stimulus. Argument order: fwd, rst, valid, flush, src1, src2, two_src, dest, wb_en, mem_r_en
  // then expected: hazard, sel1, sel2, busy_mask, stall_count.
  initial begin
    rst = 1'b1; forwarding_enabled = 1'b0; id_valid = 1'b1; flush = 1'b0;
    src1 = 4'd1; src2 = 4'd0; two_src = 1'b0; id_dest = 4'd1; id_wb_en = 1'b1; id_mem_r_en = 1'b0;
    @(posedge clk);

    // Reset held with a self-dependent instruction at ID, then release.
    cyc(0,1,1,0, 1,0,0, 1,1,0,  0,0,0,16'h0000,0);
    nop(0,0,                    0,0,0,16'h0000,0);

    // No forwarding: ADD R1 then a reader of R1 stalls for two cycles.
    cyc(0,0,1,0, 0,0,0, 1,1,0,  0,0,0,16'h0000,0);
    cyc(0,0,1,0, 1,0,0, 4,1,0,  1,0,0,16'h0002,0);
    cyc(0,0,1,0, 1,0,0, 4,1,0,  1,0,0,16'h0002,1);
    cyc(0,0,1,0, 1,0,0, 4,1,0,  0,0,0,16'h0002,2);
    nop(0,0,                    0,0,0,16'h0010,2);
    // Mid-run reset with forwarding switched on in the same cycle.
    nop(1,1,                    0,0,0,16'h0010,2);

    // Forwarding: back-to-back dependency, then one unrelated instruction in between.
    cyc(1,0,1,0, 0,0,0, 1,1,0,  0,0,0,16'h0000,0);
    cyc(1,0,1,0, 1,0,0, 5,1,0,  0,0,0,16'h0002,0);
    nop(1,0,                    0,1,0,16'h0022,0);
    cyc(1,0,1,0, 0,0,0, 1,1,0,  0,0,0,16'h0022,0);
    cyc(1,0,1,0, 7,0,0, 6,1,0,  0,0,0,16'h0022,0);
    cyc(1,0,1,0, 1,0,0, 8,1,0,  0,0,0,16'h0042,0);
    nop(1,0,                    0,2,0,16'h0142,0);
    nop(1,1,                    0,0,0,16'h0140,0);

    // Load-use: LDR R2 then two-source reader of R2 stalls once, then forwards from slot 2.
    cyc(1,0,1,0, 9,0,0, 2,1,1,  0,0,0,16'h0000,0);
    cyc(1,0,1,0, 0,2,1, 11,1,0, 1,0,0,16'h0004,0);
    cyc(1,0,1,0, 0,2,1, 11,1,0, 0,0,0,16'h0004,1);
    nop(1,0,                    0,0,2,16'h0804,1);

    // Flush suppresses a load-use hazard and the squashed dest never becomes busy.
    cyc(1,0,1,0, 0,0,0, 3,1,1,  0,0,0,16'h0800,1);
    cyc(1,0,1,1, 3,0,0, 12,1,0, 0,0,0,16'h0808,1);
    nop(1,0,                    0,0,0,16'h0008,1);
    nop(1,0,                    0,0,0,16'h0008,1);

    // R3 in slots 1 and 2: youngest wins; unused src2 match ignored.
    cyc(1,0,1,0, 0,0,0, 3,1,0,  0,0,0,16'h0000,1);
    cyc(1,0,1,0, 0,0,0, 3,1,0,  0,0,0,16'h0008,1);
    cyc(1,0,1,0, 3,3,0, 13,1,0, 0,0,0,16'h0008,1);
    nop(1,0,                    0,1,0,16'h2008,1);

    // No forwarding: unused src2 ignored, WB slot excluded, dest==src not a hazard.
    cyc(0,0,1,0, 0,13,0, 0,0,0, 0,0,0,16'h2008,1);
    cyc(0,0,1,0, 0,13,1, 0,0,0, 0,0,0,16'h2000,1);
    cyc(0,0,1,0, 5,0,0, 5,1,0,  0,0,0,16'h0000,1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
